// File: rtl/eca_prng_gen.sv
// Elementary cellular automaton PRNG: WIDTH-bit state, 8-bit Wolfram rule, N generations per request.
// Define ECA_PRNG_RULE_WR_EN to make the rule writable through rule_in/rule_wr.
module eca_prng_gen #(
    parameter int         WIDTH   = 64,
    parameter logic [7:0] RULE    = 8'd110,
    parameter int         WRAP    = 0,
    parameter int         OUT_LSB = 29,
    parameter int         OUT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             seed_valid,
    input  logic             step_req,
    input  logic [7:0]       steps_n,
    input  logic [7:0]       rule_in,
    input  logic             rule_wr,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             seed_rej,
    output logic             led_sig
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             seed_valid_q, seed_valid_d;
    logic             seed_nz_q, seed_nz_d;
    logic             step_q, step_d;
    logic [7:0]       steps_q, steps_d;
    logic [WIDTH-1:0] ca_q, ca_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             seed_rej_q, seed_rej_d;
    logic             led_q, led_d;
    logic [7:0]       rule_cur;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] ca_next;

`ifdef ECA_PRNG_RULE_WR_EN
    logic [7:0] rule_q, rule_d;

    // A write lands at the same edge as any generation, so that generation still sees the old rule.
    always_comb begin
        rule_d = rule_wr ? rule_in : rule_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rule_q <= RULE;
        end else begin
            rule_q <= rule_d;
        end
    end

    assign rule_cur = rule_q;
`else
    logic unused_rule;

    assign unused_rule = ^{rule_in, rule_wr};
    assign rule_cur    = RULE;
`endif

    // ext = {L boundary, q, R boundary}; the 3-bit slice at i is {L,C,R} for cell i.
    always_comb begin
        ext = {(WRAP != 0) ? ca_q[0] : 1'b0, ca_q, (WRAP != 0) ? ca_q[WIDTH-1] : 1'b0};
        ca_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ca_next[i] = rule_cur[ext[i +: 3]];
        end
    end

    always_comb begin
        seed_d       = seed_in;
        seed_valid_d = seed_valid;
        seed_nz_d    = |seed_in;
        step_d       = step_req;
        steps_d      = steps_n;
    end

    always_comb begin
        state_d     = state_q;
        ca_d        = ca_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        seed_rej_d  = 1'b0;
        led_d       = led_q;

        if (seed_valid_q && seed_nz_q) begin
            ca_d        = seed_q;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
        end else begin
            // A zero seed is refused but still blocks a step registered alongside it.
            if (seed_valid_q) begin
                seed_rej_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (step_q && !seed_valid_q) begin
                        cnt_d   = (steps_q == 8'd0) ? 8'd1 : steps_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    ca_d  = ca_next;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        out_data_d  = ca_next[OUT_LSB +: OUT_W];
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        led_d       = ~led_q;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            seed_q       <= '0;
            seed_valid_q <= 1'b0;
            seed_nz_q    <= 1'b0;
            step_q       <= 1'b0;
            steps_q      <= '0;
            ca_q         <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            seed_rej_q   <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            seed_valid_q <= seed_valid_d;
            seed_nz_q    <= seed_nz_d;
            step_q       <= step_d;
            steps_q      <= steps_d;
            ca_q         <= ca_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            seed_rej_q   <= seed_rej_d;
            led_q        <= led_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign seed_rej  = seed_rej_q;
    assign led_sig   = led_q;

endmodule

// File: tb/tb_eca_prng_gen.sv
// Bench for eca_prng_gen: a null-boundary and a periodic instance share stimulus and are
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_eca_prng_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] seed_in;
    logic        seed_valid;
    logic        step_req;
    logic [7:0]  steps_n;
    logic [7:0]  rule_in;
    logic        rule_wr;
    logic        out_ready;

    logic [1:0][3:0] od;
    logic [1:0]      ov, bz, rj, ld;

    int n_checks = 0;
    int n_fails  = 0;
    bit live     = 0;

    always #5 clk = ~clk;

    eca_prng_gen #(.WIDTH(64), .RULE(8'd110), .WRAP(0), .OUT_LSB(0), .OUT_W(4)) dut0 (
        .clk(clk), .reset(reset), .seed_in(seed_in), .seed_valid(seed_valid),
        .step_req(step_req), .steps_n(steps_n), .rule_in(rule_in), .rule_wr(rule_wr),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]),
        .seed_rej(rj[0]), .led_sig(ld[0])
    );

    eca_prng_gen #(.WIDTH(64), .RULE(8'd110), .WRAP(1), .OUT_LSB(0), .OUT_W(4)) dut1 (
        .clk(clk), .reset(reset), .seed_in(seed_in), .seed_valid(seed_valid),
        .step_req(step_req), .steps_n(steps_n), .rule_in(rule_in), .rule_wr(rule_wr),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]),
        .seed_rej(rj[1]), .led_sig(ld[1])
    );

    // Reference model: pending request from last cycle, then per-instance CA and handshake.
    logic [63:0] p_seed;
    bit          p_sv, p_step;
    int          p_n;
    logic [7:0]  m_rule;
    logic [63:0] m_q[2];
    int          m_left[2];
    bit          m_run[2], m_hold[2], m_valid[2], m_rej[2], m_led[2];
    logic [3:0]  m_out[2];

    function automatic logic [63:0] modelNext(input logic [63:0] q, input logic [7:0] r, input bit wrap);
        logic [63:0] n;
        int l, c, rr;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            l  = (i == 63) ? (wrap ? int'(q[0]) : 0) : int'(q[i+1]);
            c  = int'(q[i]);
            rr = (i == 0) ? (wrap ? int'(q[63]) : 0) : int'(q[i-1]);
            n[i] = r[l*4 + c*2 + rr];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            live   = 1;
            m_rule = 8'd110;
            for (int w = 0; w < 2; w++) begin
                m_q[w] = '0; m_left[w] = 0; m_run[w] = 0; m_hold[w] = 0;
                m_valid[w] = 0; m_rej[w] = 0; m_led[w] = 0; m_out[w] = '0;
            end
            p_seed = '0; p_sv = 0; p_step = 0; p_n = 0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                m_rej[w] = 0;
                if (p_sv && p_seed != 64'd0) begin
                    m_q[w] = p_seed; m_valid[w] = 0; m_left[w] = 0; m_run[w] = 0; m_hold[w] = 0;
                end else begin
                    if (p_sv) m_rej[w] = 1;
                    if (m_run[w]) begin
                        m_q[w] = modelNext(m_q[w], m_rule, w == 1);
                        m_left[w] = m_left[w] - 1;
                        if (m_left[w] == 0) begin
                            m_run[w] = 0; m_hold[w] = 1; m_valid[w] = 1; m_out[w] = m_q[w][3:0];
                        end
                    end else if (m_hold[w]) begin
                        if (out_ready) begin
                            m_hold[w] = 0; m_valid[w] = 0; m_led[w] = !m_led[w];
                        end
                    end else if (p_step && !p_sv) begin
                        m_left[w] = (p_n == 0) ? 1 : p_n;
                        m_run[w]  = 1;
                    end
                end
            end
`ifdef ECA_PRNG_RULE_WR_EN
            if (rule_wr) m_rule = rule_in;
`endif
            p_seed = seed_in; p_sv = seed_valid; p_step = step_req; p_n = int'(steps_n);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int w = 0; w < 2; w++) begin
                checkOutput($sformatf("out_valid[%0d]", w), 64'(ov[w]), 64'(m_valid[w]));
                checkOutput($sformatf("out_data[%0d]", w), 64'(od[w]), 64'(m_out[w]));
                checkOutput($sformatf("busy[%0d]", w), 64'(bz[w]), 64'(m_run[w] || m_hold[w]));
                checkOutput($sformatf("seed_rej[%0d]", w), 64'(rj[w]), 64'(m_rej[w]));
                checkOutput($sformatf("led_sig[%0d]", w), 64'(ld[w]), 64'(m_led[w]));
            end
        end
    end

    task automatic applyStimulus(input bit rst, input bit sv, input logic [63:0] sd, input bit st,
                                 input logic [7:0] n, input bit rw, input logic [7:0] r, input bit rdy);
        reset = rst; seed_valid = sv; seed_in = sd; step_req = st;
        steps_n = n; rule_wr = rw; rule_in = r; out_ready = rdy;
    endtask

    task automatic pulseSeed(input logic [63:0] v);
        seed_in = v; seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
    endtask

    task automatic pulseStep(input logic [7:0] n);
        step_req = 1'b1; steps_n = n;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic pulseRule(input logic [7:0] r);
        rule_in = r; rule_wr = 1'b1;
        @(negedge clk);
        rule_wr = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!ov[0] && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        if (!ov[0]) checkOutput("valid_timeout", 64'(ov[0]), 64'd1);
    endtask

    int c;
    logic [63:0] rs;

    initial begin
        applyStimulus(1, 0, '0, 0, 8'd0, 0, 8'd0, 1);
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 64'(ov[0]), 64'd0);
        checkOutput("reset_busy", 64'(bz[0]), 64'd0);
        checkOutput("reset_led", 64'(ld[0]), 64'd0);
        checkOutput("reset_data", 64'(od[1]), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // seed 1, one generation of rule 110 -> 0b11
        pulseSeed(64'h1);
        @(negedge clk);
        pulseStep(8'd1);
        waitValid(c);
        checkOutput("t1_latency", 64'(c), 64'd2);
        checkOutput("t1_data0", 64'(od[0]), 64'h3);
        checkOutput("t1_data1", 64'(od[1]), 64'h3);
        checkOutput("t1_model", 64'(m_out[0]), 64'h3);
        @(negedge clk);
        checkOutput("t1_valid_drop", 64'(ov[0]), 64'd0);
        checkOutput("t1_led", 64'(ld[0]), 64'd1);

        // two generations with the consumer stalling
        out_ready = 1'b0;
        pulseSeed(64'h1);
        pulseStep(8'd2);
        waitValid(c);
        checkOutput("t2_latency", 64'(c), 64'd3);
        checkOutput("t2_data", 64'(od[0]), 64'h7);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t2_stable_data", 64'(od[0]), 64'h7);
            checkOutput("t2_stable_valid", 64'(ov[0]), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2_accept_valid", 64'(ov[0]), 64'd0);
        checkOutput("t2_accept_led", 64'(ld[0]), 64'd0);

        // top bit: null boundary keeps bit 0 clear, periodic boundary sets it
        pulseSeed(64'h8000_0000_0000_0000);
        pulseStep(8'd1);
        waitValid(c);
        checkOutput("t3_null", 64'(od[0]), 64'h0);
        checkOutput("t3_wrap", 64'(od[1]), 64'h1);
        @(negedge clk);

        pulseRule(8'd90);
        pulseSeed(64'h1);
        pulseStep(8'd1);
        waitValid(c);
`ifdef ECA_PRNG_RULE_WR_EN
        checkOutput("t4_rule90", 64'(od[0]), 64'h2);
`else
        checkOutput("t4_rule_fixed", 64'(od[0]), 64'h3);
`endif
        @(negedge clk);
        pulseRule(8'd110);

        // zero seed is refused and the previous state survives
        pulseSeed(64'h0);
        @(negedge clk);
        checkOutput("t5_rej_high", 64'(rj[0]), 64'd1);
        @(negedge clk);
        checkOutput("t5_rej_low", 64'(rj[0]), 64'd0);
        pulseStep(8'd1);
        waitValid(c);
`ifdef ECA_PRNG_RULE_WR_EN
        checkOutput("t5_q_kept", 64'(od[0]), 64'h6);
`else
        checkOutput("t5_q_kept", 64'(od[0]), 64'h7);
`endif
        @(negedge clk);

        // nonzero seed aborts a long run
        pulseStep(8'd200);
        repeat (5) @(negedge clk);
        checkOutput("t6_busy", 64'(bz[0]), 64'd1);
        pulseSeed(64'h5);
        @(negedge clk);
        checkOutput("t6_abort_busy", 64'(bz[0]), 64'd0);
        checkOutput("t6_abort_valid", 64'(ov[0]), 64'd0);
        pulseStep(8'd1);
        waitValid(c);
        checkOutput("t6_from5", 64'(od[0]), 64'hF);
        @(negedge clk);

        // reset while an output is pending
        out_ready = 1'b0;
        pulseSeed(64'h1);
        pulseStep(8'd1);
        waitValid(c);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t7_valid", 64'(ov[0]), 64'd0);
        checkOutput("t7_led", 64'(ld[0]), 64'd0);
        checkOutput("t7_busy", 64'(bz[1]), 64'd0);
        out_ready = 1'b1;
        pulseStep(8'd1);
        waitValid(c);
        checkOutput("t7_q_zero", 64'(od[0]), 64'h0);
        @(negedge clk);

        // seed and step together: seed wins, no output
        seed_in = 64'h9; seed_valid = 1'b1; step_req = 1'b1; steps_n = 8'd1;
        @(negedge clk);
        seed_valid = 1'b0; step_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("t8_no_output", 64'(ov[0]), 64'd0);
        end
        checkOutput("t8_idle", 64'(bz[0]), 64'd0);
        pulseStep(8'd1);
        waitValid(c);
        checkOutput("t8_from9", 64'(od[0]), 64'hB);
        @(negedge clk);

        repeat (3000) begin
            rs = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 15) == 0, rs,
                          $urandom_range(0, 3) == 0,
                          ($urandom_range(0, 31) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8)),
                          $urandom_range(0, 19) == 0, 8'($urandom),
                          $urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        applyStimulus(0, 0, '0, 0, 8'd0, 0, 8'd0, 1);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
